// File: rtl/mem_port_arbiter.sv
// Shares one registered memory port between instruction fetch and data access.
// Data has fixed priority; a wait counter forces completion on a hung port.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_done,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          timeout_err
);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    localparam logic [7:0] TMAX = 8'(TIMEOUT);

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          squash_q, squash_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          terr_q, terr_d;

    logic          busy, tmo, fin;
    logic [DW-1:0] rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            squash_q <= 1'b0;
            cnt_q    <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            squash_q <= squash_d;
            cnt_q    <= cnt_d;
            terr_q   <= terr_d;
        end
    end

    // A transaction ends on mem_ready or when the wait budget is exhausted.
    always_comb begin
        busy = (state_q != IDLE);
        tmo  = busy && !mem_ready && (cnt_q == TMAX);
        fin  = busy && (mem_ready || tmo);
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        squash_d = squash_q;
        cnt_d    = cnt_q;
        terr_d   = terr_q | tmo;
        case (state_q)
            IDLE: begin
                if (dm_req) begin
                    state_d = DATA;
                    req_d   = 1'b1;
                    we_d    = dm_we;
                    addr_d  = dm_addr;
                    wdata_d = dm_wdata;
                    cnt_d   = '0;
                end else if (if_req && !if_flush) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    cnt_d   = '0;
                end
            end
            FETCH, DATA: begin
                if (fin) begin
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    squash_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (state_q == FETCH && if_flush) begin
                        squash_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                req_d    = 1'b0;
                squash_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        rdata   = tmo ? '0 : mem_rdata;
        if_done = (state_q == FETCH) && fin && !squash_q && !if_flush;
        dm_done = (state_q == DATA) && fin;
    end

    assign if_rdata    = rdata;
    assign dm_rdata    = rdata;
    assign stall_if    = if_req && !if_done;
    assign stall_mem   = dm_req && !dm_done;
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter with a behavioural
// memory responder and a reference model of fetch and data contents.
module tb_mem_port_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          tmo;
    } exp_t;

    logic        clk, rst_n;
    logic        if_req, if_flush, if_done;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_done;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_if, stall_mem, timeout_err;

    int          checks = 0;
    int          errors = 0;
    exp_t        dq[$];
    exp_t        fq[$];
    logic [31:0] rmem[logic [31:0]];
    logic [31:0] dmem[logic [31:0]];
    bit          hang = 0;
    bit          exp_terr = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .stall_if(stall_if),
        .stall_mem(stall_mem), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ifetch(input logic [31:0] a);
        return a ^ 32'h2048_0005;
    endfunction

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a * 32'd3 + 32'd1;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] rnd_ia();
        return 32'h0040_0000 + 32'($urandom_range(0, 255)) * 32'd4;
    endfunction

    function automatic logic [31:0] rnd_da();
        return 32'h1001_0000 + 32'($urandom_range(0, 7)) * 32'd4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory environment: random latency, random ready pulses while idle.
    initial begin
        bit busy;
        int dly;
        busy = 0;
        dly = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (!rst_n || !mem_req) begin
                busy = 0;
                if (rst_n && $urandom_range(0, 3) == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = $urandom;
                end
            end else begin
                if (!busy) begin
                    busy = 1;
                    dly = $urandom_range(0, 3);
                end
                if (hang) begin
                    mem_rdata = 32'hBAD0_BAD0;
                end else if (dly == 0) begin
                    mem_ready = 1'b1;
                    busy = 0;
                    if (mem_we) dmem[mem_addr] = mem_wdata;
                    if (mem_we) mem_rdata = $urandom;
                    else if (mem_addr[28]) mem_rdata = env_rd(mem_addr);
                    else mem_rdata = ifetch(mem_addr);
                end else begin
                    dly--;
                end
            end
        end
    end

    // Monitor: scoreboard pops plus per-cycle protocol checks.
    initial begin
        bit          p_ok, p_req, p_dm, p_dwe, p_if, p_fl;
        logic [31:0] p_da, p_dwd, p_ia, p_ma, p_mwd;
        logic        p_mwe;
        int          bc;
        exp_t        e;
        p_ok = 0;
        bc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_terr = 0;
                bc = 0;
                p_ok = 0;
            end else begin
                chk("stall_if", 32'(stall_if), 32'(if_req && !if_done));
                chk("stall_mem", 32'(stall_mem), 32'(dm_req && !dm_done));
                chk("timeout_err", 32'(timeout_err), 32'(exp_terr));
                if (p_ok && !p_req) begin
                    chk("issue", 32'(mem_req), 32'(p_dm || (p_if && !p_fl)));
                    if (mem_req && p_dm) begin
                        chk("iss_d_addr", mem_addr, p_da);
                        chk("iss_d_we", 32'(mem_we), 32'(p_dwe));
                        chk("iss_d_wd", mem_wdata, p_dwd);
                    end else if (mem_req) begin
                        chk("iss_f_addr", mem_addr, p_ia);
                        chk("iss_f_we", 32'(mem_we), 32'd0);
                        chk("iss_f_wd", mem_wdata, 32'd0);
                    end
                end
                if (p_ok && p_req && mem_req) begin
                    chk("hold_addr", mem_addr, p_ma);
                    chk("hold_we", 32'(mem_we), 32'(p_mwe));
                    chk("hold_wd", mem_wdata, p_mwd);
                end
                bc = mem_req ? bc + 1 : 0;
                if (dm_done) begin
                    if (dq.size() == 0) begin
                        chk("dm_unexp", 32'd1, 32'd0);
                    end else begin
                        e = dq.pop_front();
                        chk("dm_addr", mem_addr, e.addr);
                        chk("dm_we", 32'(mem_we), 32'(e.we));
                        if (e.we) chk("dm_wdata", mem_wdata, e.wdata);
                        else chk("dm_rdata", dm_rdata, e.rdata);
                        if (e.tmo) begin
                            chk("tmo_cycles", 32'(bc), 32'd256);
                            exp_terr = 1;
                        end
                    end
                end
                if (if_done) begin
                    if (fq.size() == 0) begin
                        chk("if_unexp", 32'd1, 32'd0);
                    end else begin
                        e = fq.pop_front();
                        chk("if_addr", mem_addr, e.addr);
                        chk("if_rdata", if_rdata, e.rdata);
                    end
                end
                p_ok = 1;
                p_req = mem_req;
                p_dm = dm_req;
                p_dwe = dm_we;
                p_da = dm_addr;
                p_dwd = dm_wdata;
                p_if = if_req;
                p_fl = if_flush;
                p_ia = if_addr;
                p_ma = mem_addr;
                p_mwe = mem_we;
                p_mwd = mem_wdata;
            end
        end
    end

    task automatic dm_op(input logic we, input logic [31:0] a,
                         input logic [31:0] d, input bit tmo);
        exp_t e;
        int n;
        @(posedge clk);
        #1;
        dm_req = 1'b1;
        dm_we = we;
        dm_addr = a;
        dm_wdata = d;
        hang = tmo;
        e.we = we;
        e.addr = a;
        e.wdata = d;
        e.tmo = tmo;
        e.rdata = (tmo || we) ? 32'd0 : ref_rd(a);
        if (we && !tmo) rmem[a] = d;
        dq.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dm_done && n < 400);
        chk("dm_wait", 32'(dm_done), 32'd1);
        @(posedge clk);
        #1;
        dm_req = 1'b0;
        hang = 0;
    endtask

    task automatic fetch_run(input int cnt);
        exp_t e;
        int n;
        for (int i = 0; i < cnt; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk);
            #1;
            if_req = 1'b1;
            if_addr = (i == 0) ? 32'h0040_0000 : rnd_ia();
            e.we = 1'b0;
            e.addr = if_addr;
            e.wdata = '0;
            e.rdata = ifetch(if_addr);
            e.tmo = 0;
            fq.push_back(e);
            n = 0;
            forever begin
                @(negedge clk);
                if (if_done) break;
                n++;
                if (n >= 400) begin
                    chk("if_wait", 32'(if_done), 32'd1);
                    break;
                end
                @(posedge clk);
                #1;
                if_flush = 1'b0;
                if ($urandom_range(0, 7) == 0) begin
                    if_flush = 1'b1;
                    void'(fq.pop_back());
                    if_addr = rnd_ia();
                    e.addr = if_addr;
                    e.rdata = ifetch(if_addr);
                    fq.push_back(e);
                end
            end
            @(posedge clk);
            #1;
            if_req = 1'b0;
            if_flush = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int n;
        rst_n = 1'b0;
        if_req = 1'b0;
        if_addr = '0;
        if_flush = 1'b0;
        dm_req = 1'b0;
        dm_we = 1'b0;
        dm_addr = '0;
        dm_wdata = '0;
        #12;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_dm_done", 32'(dm_done), 32'd0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        fork
            fetch_run(40);
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                dm_op(1'($urandom_range(0, 1)), rnd_da(), $urandom, 0);
            end
        join
        repeat (3) @(negedge clk);
        chk("dq_empty", 32'(dq.size()), 32'd0);
        chk("fq_empty", 32'(fq.size()), 32'd0);

        dm_op(1'b0, 32'h1001_0008, 32'd0, 1);
        dm_op(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 0);
        dm_op(1'b0, 32'h1001_0004, 32'd0, 0);
        fetch_run(3);

        @(posedge clk);
        #1;
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_addr = 32'h1001_0010;
        hang = 1;
        e.we = 1'b0;
        e.addr = dm_addr;
        e.wdata = '0;
        e.rdata = ref_rd(dm_addr);
        e.tmo = 0;
        dq.push_back(e);
        repeat (4) @(negedge clk);
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'd0);
        chk("arst_dm_done", 32'(dm_done), 32'd0);
        chk("arst_terr", 32'(timeout_err), 32'd0);
        hang = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dm_done && n < 400);
        chk("reissue_done", 32'(dm_done), 32'd1);
        @(posedge clk);
        #1;
        dm_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("end_dq_empty", 32'(dq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
